// File: rtl/heartbeat_monitor.sv
// Heartbeat period watchdog: measures the interval between rising edges of hb,
// declares lock after LOCK in-window intervals and keeps sticky early/missing flags.
module heartbeat_monitor #(
  parameter int W    = 16,
  parameter int EXP  = 256,
  parameter int TOL  = 2,
  parameter int LOCK = 4
) (
  input  logic         clk,
  input  logic         nreset,
  input  logic         hb,
  input  logic         clear,
  output logic         locked,
  output logic         early,
  output logic         missing,
  output logic [W-1:0] period,
  output logic [7:0]   hb_count
);

  localparam logic [W-1:0] WIN_LO   = W'(EXP - TOL);
  localparam logic [W-1:0] WIN_HI   = W'(EXP + TOL);
  localparam logic [W-1:0] CNT_ZERO = {W{1'b0}};
  localparam logic [W-1:0] CNT_ONE  = {{(W-1){1'b0}}, 1'b1};
  localparam logic [7:0]   LOCK_RUN = 8'(LOCK);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_TRACK  = 2'd1,
    S_LOCKED = 2'd2
  } state_e;

  state_e       state_q, state_d;
  logic         hb_q;
  logic [W-1:0] cnt_q, cnt_d;
  logic [7:0]   run_q, run_d;
  logic [7:0]   run_inc_s;
  logic [W-1:0] period_q, period_d;
  logic [7:0]   hb_count_q, hb_count_d;
  logic         locked_q;
  logic         early_q, early_d;
  logic         missing_q, missing_d;

  logic hb_edge_s, tracking_s, good_s, early_evt_s, timeout_s;

  // The measured interval is the pre-update count, so classification uses cnt_q.
  assign hb_edge_s   = hb & ~hb_q;
  assign tracking_s  = (state_q != S_IDLE);
  assign good_s      = tracking_s & hb_edge_s & (cnt_q >= WIN_LO) & (cnt_q <= WIN_HI);
  assign early_evt_s = tracking_s & hb_edge_s & (cnt_q < WIN_LO);
  assign timeout_s   = tracking_s & ~hb_edge_s & (cnt_q == WIN_HI);
  assign run_inc_s   = run_q + 8'd1;

  // Next-state logic for the FSM, interval counter, period, count and flags.
  always_comb begin
    state_d    = state_q;
    run_d      = run_q;
    period_d   = period_q;
    hb_count_d = hb_count_q;

    if (hb_edge_s) begin
      cnt_d = CNT_ONE;
    end else if (state_q == S_IDLE) begin
      cnt_d = CNT_ZERO;
    end else begin
      cnt_d = cnt_q + CNT_ONE;
    end

    case (state_q)
      S_IDLE: begin
        if (hb_edge_s) begin
          state_d = S_TRACK;
          run_d   = 8'd0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_TRACK: begin
        if (good_s) begin
          run_d = run_inc_s;
          if (run_inc_s == LOCK_RUN) begin
            state_d = S_LOCKED;
          end else begin
            state_d = S_TRACK;
          end
        end else if (early_evt_s) begin
          run_d = 8'd0;
        end else if (timeout_s) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_TRACK;
        end
      end
      S_LOCKED: begin
        if (early_evt_s) begin
          state_d = S_TRACK;
          run_d   = 8'd0;
        end else if (timeout_s) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_LOCKED;
        end
      end
      default: begin
        state_d = S_IDLE;
        run_d   = 8'd0;
      end
    endcase

    if (good_s || early_evt_s) begin
      period_d = cnt_q;
    end else begin
      period_d = period_q;
    end

    // A good edge coinciding with clear leaves exactly that edge counted.
    if (good_s) begin
      if (clear) begin
        hb_count_d = 8'd1;
      end else if (hb_count_q == 8'hFF) begin
        hb_count_d = hb_count_q;
      end else begin
        hb_count_d = hb_count_q + 8'd1;
      end
    end else if (clear) begin
      hb_count_d = 8'd0;
    end else begin
      hb_count_d = hb_count_q;
    end

    early_d   = (early_q & ~clear) | early_evt_s;
    missing_d = (missing_q & ~clear) | timeout_s;
  end

  // State and output registers.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q    <= S_IDLE;
      hb_q       <= 1'b0;
      cnt_q      <= CNT_ZERO;
      run_q      <= 8'd0;
      period_q   <= CNT_ZERO;
      hb_count_q <= 8'd0;
      locked_q   <= 1'b0;
      early_q    <= 1'b0;
      missing_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      hb_q       <= hb;
      cnt_q      <= cnt_d;
      run_q      <= run_d;
      period_q   <= period_d;
      hb_count_q <= hb_count_d;
      locked_q   <= (state_d == S_LOCKED);
      early_q    <= early_d;
      missing_q  <= missing_d;
    end
  end

  assign locked   = locked_q;
  assign early    = early_q;
  assign missing  = missing_q;
  assign period   = period_q;
  assign hb_count = hb_count_q;

endmodule

// File: tb/tb_heartbeat_monitor.sv
// Directed bench for heartbeat_monitor: a table of pulse intervals with expected
// outputs, plus hand sequences for clear, missing, held-high pulses and reset.
module tb_heartbeat_monitor;

  logic        clk;
  logic        nreset;
  logic        hb;
  logic        clear;
  logic        locked;
  logic        early;
  logic        missing;
  logic [15:0] period;
  logic [7:0]  hb_count;

  int checks = 0;
  int errors = 0;
  int since  = 0;

  heartbeat_monitor #(.W(16), .EXP(256), .TOL(2), .LOCK(4)) dut (
    .clk      (clk),
    .nreset   (nreset),
    .hb       (hb),
    .clear    (clear),
    .locked   (locked),
    .early    (early),
    .missing  (missing),
    .period   (period),
    .hb_count (hb_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         gap;
    bit         clr;
    bit         lk;
    bit         er;
    bit         ms;
    logic [15:0] per;
    logic [7:0]  cnt;
  } vec_t;

  vec_t tbl[15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input bit lk, input bit er, input bit ms,
                           input logic [15:0] per, input logic [7:0] cnt);
    chk({tag, ".locked"},   {31'd0, locked},  {31'd0, lk});
    chk({tag, ".early"},    {31'd0, early},   {31'd0, er});
    chk({tag, ".missing"},  {31'd0, missing}, {31'd0, ms});
    chk({tag, ".period"},   {16'd0, period},  {16'd0, per});
    chk({tag, ".hb_count"}, {24'd0, hb_count}, {24'd0, cnt});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    since++;
  endtask

  // Edge lands exactly `interval` cycles after the previous edge; hb held `width` cycles.
  task automatic pulse(input int interval, input bit clr, input int width);
    repeat (interval - 1 - since) tick();
    hb    = 1'b1;
    clear = clr;
    @(posedge clk);
    #1;
    since = 0;
    clear = 1'b0;
    repeat (width - 1) tick();
    hb = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    tbl[0]  = '{5,   1'b0, 1'b0, 1'b0, 1'b0, 16'd0,   8'd0};
    tbl[1]  = '{256, 1'b0, 1'b0, 1'b0, 1'b0, 16'd256, 8'd1};
    tbl[2]  = '{256, 1'b0, 1'b0, 1'b0, 1'b0, 16'd256, 8'd2};
    tbl[3]  = '{256, 1'b0, 1'b0, 1'b0, 1'b0, 16'd256, 8'd3};
    tbl[4]  = '{256, 1'b0, 1'b1, 1'b0, 1'b0, 16'd256, 8'd4};
    tbl[5]  = '{254, 1'b0, 1'b1, 1'b0, 1'b0, 16'd254, 8'd5};
    tbl[6]  = '{258, 1'b0, 1'b1, 1'b0, 1'b0, 16'd258, 8'd6};
    tbl[7]  = '{253, 1'b0, 1'b0, 1'b1, 1'b0, 16'd253, 8'd6};
    tbl[8]  = '{256, 1'b0, 1'b0, 1'b1, 1'b0, 16'd256, 8'd7};
    tbl[9]  = '{256, 1'b1, 1'b0, 1'b0, 1'b0, 16'd256, 8'd1};
    tbl[10] = '{100, 1'b1, 1'b0, 1'b1, 1'b0, 16'd100, 8'd0};
    tbl[11] = '{256, 1'b0, 1'b0, 1'b1, 1'b0, 16'd256, 8'd1};
    tbl[12] = '{256, 1'b0, 1'b0, 1'b1, 1'b0, 16'd256, 8'd2};
    tbl[13] = '{256, 1'b0, 1'b0, 1'b1, 1'b0, 16'd256, 8'd3};
    tbl[14] = '{256, 1'b0, 1'b1, 1'b1, 1'b0, 16'd256, 8'd4};

    nreset = 1'b0;
    hb     = 1'b0;
    clear  = 1'b0;
    #12;
    check_all("reset", 1'b0, 1'b0, 1'b0, 16'd0, 8'd0);
    @(negedge clk);
    nreset = 1'b1;
    @(posedge clk);
    #1;
    since = 0;

    for (int i = 0; i < 15; i++) begin
      pulse(tbl[i].gap, tbl[i].clr, 1);
      check_all($sformatf("vec%0d", i), tbl[i].lk, tbl[i].er, tbl[i].ms, tbl[i].per, tbl[i].cnt);
    end

    // clear alone: flags and count drop, lock is untouched
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check_all("clear_only", 1'b1, 1'b0, 1'b0, 16'd256, 8'd0);

    // missing: no pulse after the last edge
    repeat (257 - since) tick();
    check_all("pre_timeout", 1'b1, 1'b0, 1'b0, 16'd256, 8'd0);
    tick();
    check_all("timeout", 1'b0, 1'b0, 1'b1, 16'd256, 8'd0);
    pulse(259, 1'b0, 1);
    check_all("rearm", 1'b0, 1'b0, 1'b1, 16'd256, 8'd0);
    for (int i = 1; i <= 4; i++) begin
      pulse(256, 1'b0, 1);
      check_all($sformatf("relock%0d", i), (i == 4), 1'b0, 1'b1, 16'd256, 8'(i));
    end

    // held-high pulses count once per interval
    for (int i = 1; i <= 4; i++) begin
      pulse(256, 1'b0, 10);
      check_all($sformatf("held%0d", i), 1'b1, 1'b0, 1'b1, 16'd256, 8'(4 + i));
    end

    // asynchronous reset mid-interval while locked
    repeat (50) tick();
    #2;
    nreset = 1'b0;
    #1;
    check_all("async_rst", 1'b0, 1'b0, 1'b0, 16'd0, 8'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    nreset = 1'b1;
    @(posedge clk);
    #1;
    since = 0;
    pulse(10, 1'b0, 1);
    check_all("post_rst_arm", 1'b0, 1'b0, 1'b0, 16'd0, 8'd0);
    pulse(256, 1'b0, 1);
    check_all("post_rst_good", 1'b0, 1'b0, 1'b0, 16'd256, 8'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
